// File: rtl/matrix_frame_ctrl_if.sv
// Host/driver-facing bundle of matrix_frame_ctrl.
// MATRIX_FRAME_READBACK_EN adds the rd/rdata back-buffer read port.
interface matrix_frame_ctrl_if #(
   parameter int BW = 4
);
   logic          wr;
   logic [2:0]    addr;
   logic [7:0]    wdata;
   logic          swap;
   logic          enable;
   logic [BW-1:0] bright;
   logic          ready;
   logic          frame;
   logic          oe;
   logic [63:0]   data;
`ifdef MATRIX_FRAME_READBACK_EN
   logic          rd;
   logic [7:0]    rdata;

   modport master (
      output wr, addr, wdata, swap,
      output enable, bright, rd,
      input  ready, frame, oe, data,
      input  rdata
   );

   modport slave (
      input  wr, addr, wdata, swap,
      input  enable, bright, rd,
      output ready, frame, oe, data,
      output rdata
   );
`else
   modport master (
      output wr, addr, wdata, swap,
      output enable, bright,
      input  ready, frame, oe, data
   );

   modport slave (
      input  wr, addr, wdata, swap,
      input  enable, bright,
      output ready, frame, oe, data
   );
`endif
endinterface

// File: rtl/matrix_frame_ctrl.sv
// Double-buffered 8x8 frame controller with tear-free swap and OE duty.
// MATRIX_FRAME_READBACK_EN adds a one-cycle-latency back-buffer read.
module matrix_frame_ctrl #(
   parameter int BW = 4
) (
   input  logic               i_clk,
   input  logic               i_rst,
   matrix_frame_ctrl_if.slave bus
);

   logic [7:0]    r_buf_a [8];
   logic [7:0]    r_buf_b [8];
   logic          r_front;
   logic          r_pend;
   logic          r_oe;
   logic          r_frame;
   logic [2:0]    r_ph;
   logic [BW-1:0] r_fcnt;

   logic          w_ready;
   logic          w_bnd;
   logic          w_wr;
   logic          w_swap_req;
   logic          w_swap_do;
   logic [BW-1:0] w_fcnt_nxt;
   logic [63:0]   w_data;

   assign w_ready    = ~r_pend;
   assign w_bnd      = bus.enable && (r_ph == 3'd7);
   assign w_wr       = bus.wr && w_ready;
   assign w_swap_req = bus.swap && w_ready;
   // A disabled display has no frame to protect.
   assign w_swap_do  = r_pend && (w_bnd || !bus.enable);
   assign w_fcnt_nxt = r_fcnt + 1'b1;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < 8; i++) begin
            r_buf_a[i] <= '0;
            r_buf_b[i] <= '0;
         end
      end else if (w_wr) begin
         if (r_front)
            r_buf_a[bus.addr] <= bus.wdata;
         else
            r_buf_b[bus.addr] <= bus.wdata;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_front <= 1'b0;
         r_pend  <= 1'b0;
      end else if (w_swap_do) begin
         r_front <= ~r_front;
         r_pend  <= 1'b0;
      end else if (w_swap_req) begin
         r_pend  <= 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ph    <= '0;
         r_fcnt  <= '0;
         r_oe    <= 1'b0;
         r_frame <= 1'b0;
      end else begin
         r_frame <= w_bnd;
         if (!bus.enable) begin
            r_ph <= '0;
            r_oe <= 1'b0;
         end else begin
            r_ph <= r_ph + 3'd1;
            if (w_bnd) begin
               r_fcnt <= w_fcnt_nxt;
               r_oe   <= (w_fcnt_nxt <= bus.bright);
            end
         end
      end
   end

   always_comb begin
      w_data = '0;
      for (int r = 0; r < 8; r++) begin
         w_data[8*r +: 8] = r_front ? r_buf_b[r]
                                    : r_buf_a[r];
      end
   end

   assign bus.ready = w_ready;
   assign bus.frame = r_frame;
   assign bus.oe    = r_oe;
   assign bus.data  = w_data;

`ifdef MATRIX_FRAME_READBACK_EN
   logic [7:0] r_rdata;

   // Reads see the pre-write byte on a same-cycle write.
   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_rdata <= '0;
      else if (bus.rd)
         r_rdata <= r_front ? r_buf_a[bus.addr]
                            : r_buf_b[bus.addr];
   end

   assign bus.rdata = r_rdata;
`endif

endmodule

// File: tb/tb_matrix_frame_ctrl.sv
// Self-checking bench for matrix_frame_ctrl.
// Vector table for swap/write flow, directed runs for duty and reset.
module tb_matrix_frame_ctrl;

   localparam logic [63:0] D0 = 64'h0;
   localparam logic [63:0] D1 = 64'h8040201008040201;
   localparam logic [63:0] D2 = 64'h8040201008AA0201;

   typedef struct {
      logic        rst;
      logic        wr;
      logic [2:0]  addr;
      logic [7:0]  wdata;
      logic        swap;
      logic        e_ready;
      logic        e_oe;
      logic        e_frame;
      logic [63:0] e_data;
   } vec_t;

   logic clk;
   logic rst;
   int   n_run;
   int   n_fail;
   vec_t tbl [$];

   matrix_frame_ctrl_if #(.BW(4)) bus_if ();

   matrix_frame_ctrl #(.BW(4)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus_if.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: sim time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic step(input logic       r_v,
                       input logic       wr_v,
                       input logic [2:0] ad_v,
                       input logic [7:0] wd_v,
                       input logic       sw_v,
                       input logic       en_v,
                       input logic [3:0] br_v);
      rst           = r_v;
      bus_if.wr     = wr_v;
      bus_if.addr   = ad_v;
      bus_if.wdata  = wd_v;
      bus_if.swap   = sw_v;
      bus_if.enable = en_v;
      bus_if.bright = br_v;
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic        r_v,
                      input logic        wr_v,
                      input logic [2:0]  ad_v,
                      input logic [7:0]  wd_v,
                      input logic        sw_v,
                      input logic        e_r,
                      input logic        e_o,
                      input logic        e_f,
                      input logic [63:0] e_d);
      vec_t v;
      v.rst     = r_v;
      v.wr      = wr_v;
      v.addr    = ad_v;
      v.wdata   = wd_v;
      v.swap    = sw_v;
      v.e_ready = e_r;
      v.e_oe    = e_o;
      v.e_frame = e_f;
      v.e_data  = e_d;
      tbl.push_back(v);
   endtask

   task automatic idle(input int n,
                       input logic e_r,
                       input logic e_o,
                       input logic [63:0] e_d);
      for (int k = 0; k < n; k++)
         add(0, 0, 3'd0, 8'h0, 0, e_r, e_o, 0, e_d);
   endtask

   initial begin
      int ones;
      int bad_tr;
      int lat;
      logic prev;

      n_run  = 0;
      n_fail = 0;
`ifdef MATRIX_FRAME_READBACK_EN
      bus_if.rd = 1'b0;
`endif

      // reset, then write rows 0..7 during the first frame
      add(1, 0, 3'd0, 8'h0, 0, 1, 0, 0, D0);
      for (int i = 0; i < 8; i++)
         add(0, 1, i[2:0], 8'(1 << i), 0,
             1, (i == 7), (i == 7), D0);
      // SWAP at ph=3, dropped write at ph=4
      idle(3, 1, 1, D0);
      add(0, 0, 3'd0, 8'h0, 1, 0, 1, 0, D0);
      add(0, 1, 3'd2, 8'hAA, 0, 0, 1, 0, D0);
      idle(2, 0, 1, D0);
      add(0, 0, 3'd0, 8'h0, 0, 1, 1, 1, D1);
      // SWAP on the boundary edge waits a whole frame
      idle(7, 1, 1, D1);
      add(0, 0, 3'd0, 8'h0, 1, 0, 1, 1, D1);
      idle(7, 0, 1, D1);
      add(0, 0, 3'd0, 8'h0, 0, 1, 1, 1, D0);
      // WR+SWAP together; back still holds old image
      add(0, 1, 3'd2, 8'hAA, 1, 0, 1, 0, D0);
      idle(6, 0, 1, D0);
      add(0, 0, 3'd0, 8'h0, 0, 1, 1, 1, D2);

      foreach (tbl[i]) begin
         step(tbl[i].rst, tbl[i].wr, tbl[i].addr,
              tbl[i].wdata, tbl[i].swap, 1'b1, 4'hF);
         chk($sformatf("v%0d ready", i),
             64'(bus_if.ready), 64'(tbl[i].e_ready));
         chk($sformatf("v%0d oe", i),
             64'(bus_if.oe), 64'(tbl[i].e_oe));
         chk($sformatf("v%0d frame", i),
             64'(bus_if.frame), 64'(tbl[i].e_frame));
         chk($sformatf("v%0d data", i),
             bus_if.data, tbl[i].e_data);
      end

      // duty: BRIGHT=3 -> 32 of 128 cycles lit
      for (int k = 0; k < 7; k++)
         step(0, 0, 3'd0, 8'h0, 0, 1, 4'h3);
      prev   = bus_if.oe;
      ones   = 0;
      bad_tr = 0;
      for (int k = 0; k < 128; k++) begin
         step(0, 0, 3'd0, 8'h0, 0, 1, 4'h3);
         if (bus_if.oe === 1'b1) ones++;
         if (bus_if.oe !== prev && bus_if.frame !== 1'b1)
            bad_tr++;
         prev = bus_if.oe;
      end
      chk("duty lit cycles", 64'(ones), 64'd32);
      chk("oe off-boundary edges", 64'(bad_tr), 64'd0);

      // ENABLE=0 mid-frame blanks on the next edge
      for (int k = 0; k < 19; k++)
         step(0, 0, 3'd0, 8'h0, 0, 1, 4'hF);
      chk("oe lit before disable", 64'(bus_if.oe), 64'd1);
      step(0, 0, 3'd0, 8'h0, 0, 0, 4'hF);
      chk("oe after disable", 64'(bus_if.oe), 64'd0);
      chk("frame after disable", 64'(bus_if.frame), 64'd0);
      step(0, 0, 3'd0, 8'h0, 0, 0, 4'hF);
      chk("oe stays blank", 64'(bus_if.oe), 64'd0);

      // pending swap with ENABLE=0 runs on the next edge
      step(0, 0, 3'd0, 8'h0, 1, 0, 4'hF);
      chk("dis swap ready", 64'(bus_if.ready), 64'd0);
      chk("dis swap old data", bus_if.data, D2);
      step(0, 0, 3'd0, 8'h0, 0, 0, 4'hF);
      chk("dis swap done", 64'(bus_if.ready), 64'd1);
      chk("dis swap data", bus_if.data, D0);
      step(0, 0, 3'd0, 8'h0, 1, 0, 4'hF);
      step(0, 0, 3'd0, 8'h0, 0, 0, 4'hF);
      chk("dis swap back data", bus_if.data, D2);

      // ph held at 0: boundary is exactly 8 edges out
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         step(0, 0, 3'd0, 8'h0, 0, 1, 4'hF);
         if (lat == 0 && bus_if.frame === 1'b1) lat = k;
         if (lat != 0) break;
      end
      chk("re-enable frame latency", 64'(lat), 64'd8);

      // reset with swap pending at ph=5
      step(0, 0, 3'd0, 8'h0, 0, 1, 4'hF);
      step(0, 0, 3'd0, 8'h0, 0, 1, 4'hF);
      step(0, 0, 3'd0, 8'h0, 1, 1, 4'hF);
      chk("pre-rst pending", 64'(bus_if.ready), 64'd0);
      step(0, 0, 3'd0, 8'h0, 0, 1, 4'hF);
      step(0, 0, 3'd0, 8'h0, 0, 1, 4'hF);
      step(1, 0, 3'd0, 8'h0, 0, 1, 4'hF);
      chk("rst data", bus_if.data, D0);
      chk("rst ready", 64'(bus_if.ready), 64'd1);
      chk("rst oe", 64'(bus_if.oe), 64'd0);
      chk("rst frame", 64'(bus_if.frame), 64'd0);

      // no stale swap; first lit frame after first boundary
      for (int k = 0; k < 8; k++) begin
         step(0, (k == 0), 3'd0, 8'h55, 0, 1, 4'hF);
         chk($sformatf("post-rst oe %0d", k),
             64'(bus_if.oe), 64'(k == 7));
         chk($sformatf("post-rst data %0d", k),
             bus_if.data, D0);
      end
      step(0, 0, 3'd0, 8'h0, 1, 0, 4'hF);
      step(0, 0, 3'd0, 8'h0, 0, 0, 4'hF);
      chk("post-rst back cleared", bus_if.data, 64'h55);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/matrix_frame_ctrl.md
Name: matrix_frame_ctrl

Overview:
- Double-buffered frame controller feeding the 8x8 LED matrix row-scan driver.
- The host (MCS-51 bus glue) writes row bytes into a back buffer and requests a swap. The block swaps front and back buffers only on a scan-frame boundary, so the display never tears.
- The block also drives the driver's OE for frame-level brightness duty and global blanking.
- It sits between the host bus interface and the driver's OE/DATA inputs, and shares the driver's CLK.

Parameters:
- BW, 4, brightness/duty counter width. One duty period is 2^BW frames.

Ports:
- CLK  in  1  system clock, the same clock as the scan driver
- RST  in  1  synchronous, active-high reset
- WR  in  1  host write strobe, one cycle per byte
- ADDR  in  3  row index for the write
- WDATA  in  8  row byte, column bits
- SWAP  in  1  swap request pulse
- ENABLE  in  1  display enable; 0 blanks and halts scanning
- BRIGHT  in  BW  duty setting; a frame is lit iff fcnt <= BRIGHT
- READY  out  1  high when writes and swaps are accepted (= !pending)
- FRAME  out  1  one-cycle pulse after each frame boundary
- OE  out  1  to driver OE, registered
- DATA  out  64  to driver DATA; row r of the front buffer on bits [8r+7:8r]

Behaviour:
- Storage:
  - Two 8x8-bit buffers, A and B.
  - Register `front` selects the displayed buffer; the other buffer is the back buffer.
  - DATA is combinational from the front buffer registers.
- Phase counter ph[2:0]:
  - Mirrors the driver's internal row select.
  - ENABLE=1: ph increments every cycle and wraps 7->0.
  - ENABLE=0: ph is held at 0.
- Frame boundary: the edge at which ENABLE=1 and ph==7.
- OE timing:
  - OE updates only at a frame boundary: OE <= ENABLE && (fcnt_next <= BRIGHT).
  - At the boundary edge the driver still samples the old OE. When OE rises, the driver therefore resets its select to 0 in step with ph=0.
  - ENABLE=0: OE <= 0 on the next edge, not waiting for a boundary.
- Duty counter fcnt[BW-1:0]:
  - Increments at every frame boundary and wraps.
  - Lit frames per period = BRIGHT+1. BRIGHT=all-ones gives always lit.
  - BRIGHT is sampled only at the boundary.
- Write:
  - On an edge with WR && READY: back[ADDR] <= WDATA.
  - WR while READY=0 is dropped silently.
- Swap request:
  - On an edge with SWAP && READY: pending <= 1, so READY falls in the next cycle.
  - SWAP while pending is ignored.
  - WR and SWAP in the same cycle (READY=1): the write lands in the back buffer, then pending is set. The written byte is part of the swapped frame.
- Swap execution:
  - At the first frame boundary strictly after pending was set: front <= ~front and pending <= 0, on the same edge.
  - The driver samples row 7 of the old frame on that edge and row 0 of the new frame on the next edge.
  - A SWAP accepted on a boundary edge waits for the following boundary.
  - With ENABLE=0, a pending swap executes on the next edge.
  - Swaps occur on boundaries regardless of OE, including blanked duty frames.
- After a swap the new back buffer holds the previously displayed image. There is no copy and no clear.
- FRAME: registered, high for the one cycle following each boundary edge.
- Reset (synchronous; any cycle, including mid-frame or with a swap pending):
  - Both buffers = 0, front = A.
  - ph = 0, fcnt = 0, pending = 0.
  - OE = 0, FRAME = 0, so READY = 1 and DATA = 0.
  - The first lit frame begins after the first boundary following reset.

Optional Feature:
- Macro: MATRIX_FRAME_READBACK_EN
- Defined:
  - Adds input RD (1) and output RDATA (8).
  - On an edge with RD: RDATA <= back[ADDR], giving a one-cycle read latency.
  - RD and WR to the same ADDR in one cycle returns the old byte.
  - RDATA resets to 0.
- Undefined: neither port exists and no read logic is generated.

Test Plan:
- Reset, then ENABLE=1, BRIGHT=4'hF -> OE=0 for cycles 0-7, OE=1 from the first boundary; FRAME pulses every 8 cycles; DATA=0.
- Write rows 0..7 = 8'h01,8'h02,..,8'h80, then SWAP at ph=3 -> READY low; DATA unchanged until the ph==7 edge, then 64'h8040201008040201; READY high the cycle after.
- SWAP exactly on a boundary edge -> swap at the next boundary, 8 cycles later, not immediately.
- WR while READY=0 (ADDR=2, WDATA=8'hAA) -> ignored; after the swap the back buffer row 2 still holds the displayed-before image.
- BRIGHT=4'h3, ENABLE=1 -> OE high for 4 of every 16 frames (32 of 128 cycles), with transitions only at boundaries; ENABLE=0 mid-frame -> OE=0 next cycle, ph held 0.
- RST asserted with a swap pending at ph=5 -> next cycle front=A, DATA=0, READY=1, OE=0, and no swap occurs.
